// File: rtl/opread_pkg.sv
// Shared widths, FSM state and hazard-reason types for the operand read unit.
// Optional feature macro used by this slice: OPREAD_STALL_STATS_EN.
package opread_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int NREGS  = 1 << REG_AW;

  typedef enum logic [1:0] {
    EMPTY,
    VALID,
    STALL
  } state_t;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_RAW1,
    HZ_RAW2,
    HZ_WAW
  } hazard_t;
endpackage

// File: rtl/pending_table.sv
// Per-register pending-write bits; set and clear in one cycle, set wins on the same register.
// Latency: 1 cycle from set/clear to dirty_vec; flush clears everything, no backpressure.
module pending_table
  import opread_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_reg,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_reg,
  input  logic              flush,
  output logic [NREGS-1:0]  dirty_vec
);
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_reg] = 1'b1;
    if (clr_en) clr_mask[clr_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else if (flush) begin
      pend_q <= '0;
    end else begin
      // Set applied after clear so a same-register retire cannot drop a fresh issue.
      pend_q <= (pend_q & ~clr_mask) | set_mask;
    end
  end

  assign dirty_vec = pend_q;
endmodule

// File: rtl/operand_read_unit.sv
// Reads operands, stalls on RAW/WAW against the pending table, forwards write-back data.
// Latency 1 cycle issue->op_valid; op_* held while !op_ready. Macro OPREAD_STALL_STATS_EN adds stall_cnt.
module operand_read_unit
  import opread_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] issue_rreg1,
  input  logic [REG_AW-1:0] issue_rreg2,
  input  logic              issue_use1,
  input  logic              issue_use2,
  input  logic              issue_wen,
  input  logic [REG_AW-1:0] issue_wreg,
  output logic [REG_AW-1:0] rf_rreg1,
  output logic [REG_AW-1:0] rf_rreg2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              wb_valid,
  input  logic              wb_skip,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_wen,
  output logic [REG_AW-1:0] op_wreg,
`ifdef OPREAD_STALL_STATS_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [NREGS-1:0]  dirty_vec
);
  state_t           state_q, state_d;
  hazard_t          hz;
  logic             out_free, accept, op_valid_d;
  logic             wb_hit1, wb_hit2, wb_hitw, fwd1, fwd2;
  logic [NREGS-1:0] pending;

  assign rf_rreg1 = issue_rreg1;
  assign rf_rreg2 = issue_rreg2;

  assign wb_hit1 = wb_valid && (wb_reg == issue_rreg1);
  assign wb_hit2 = wb_valid && (wb_reg == issue_rreg2);
  assign wb_hitw = wb_valid && (wb_reg == issue_wreg);
  // Skipped retires resolve the hazard but the register file already holds the value.
  assign fwd1    = wb_hit1 && !wb_skip;
  assign fwd2    = wb_hit2 && !wb_skip;

  always_comb begin
    hz = HZ_NONE;
    if (issue_use1 && pending[issue_rreg1] && !wb_hit1)      hz = HZ_RAW1;
    else if (issue_use2 && pending[issue_rreg2] && !wb_hit2) hz = HZ_RAW2;
    else if (issue_wen && pending[issue_wreg] && !wb_hitw)   hz = HZ_WAW;
  end

  assign out_free    = !op_valid || op_ready;
  assign accept      = issue_valid && out_free && (hz == HZ_NONE) && !flush;
  assign issue_ready = accept;

  pending_table u_pending (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && issue_wen),
    .set_reg  (issue_wreg),
    .clr_en   (wb_valid),
    .clr_reg  (wb_reg),
    .flush    (flush),
    .dirty_vec(pending)
  );
  assign dirty_vec = pending;

  always_comb begin
    state_d    = state_q;
    op_valid_d = op_valid && !op_ready;
    if (flush) begin
      state_d    = EMPTY;
      op_valid_d = 1'b0;
    end else if (accept) begin
      state_d    = VALID;
      op_valid_d = 1'b1;
    end else if (issue_valid) begin
      state_d = STALL;
    end else if (op_valid && op_ready) begin
      state_d = EMPTY;
    end else if (state_q == STALL) begin
      state_d = op_valid ? VALID : EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_wen   <= 1'b0;
      op_wreg  <= '0;
    end else begin
      state_q  <= state_d;
      op_valid <= op_valid_d;
      if (accept) begin
        op_a    <= fwd1 ? wb_data : rf_rd1;
        op_b    <= fwd2 ? wb_data : rf_rd2;
        op_wen  <= issue_wen;
        op_wreg <= issue_wreg;
      end
    end
  end

`ifdef OPREAD_STALL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_operand_read_unit.sv
// Directed bench for operand_read_unit: hazards, forwarding, hold, flush and reset.
module tb_operand_read_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_rreg1, issue_rreg2, issue_wreg;
  logic        issue_use1, issue_use2, issue_wen;
  logic [2:0]  rf_rreg1, rf_rreg2;
  logic [15:0] rf_rd1, rf_rd2;
  logic        wb_valid, wb_skip;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        flush;
  logic        op_valid, op_ready;
  logic [15:0] op_a, op_b;
  logic        op_wen;
  logic [2:0]  op_wreg;
  logic [7:0]  dirty_vec;
`ifdef OPREAD_STALL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_read_unit dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rreg1(issue_rreg1), .issue_rreg2(issue_rreg2),
    .issue_use1(issue_use1), .issue_use2(issue_use2),
    .issue_wen(issue_wen), .issue_wreg(issue_wreg),
    .rf_rreg1(rf_rreg1), .rf_rreg2(rf_rreg2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_valid(wb_valid), .wb_skip(wb_skip), .wb_reg(wb_reg), .wb_data(wb_data),
    .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_wen(op_wen), .op_wreg(op_wreg),
`ifdef OPREAD_STALL_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .dirty_vec(dirty_vec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rreg1 = 0; issue_rreg2 = 0; issue_use1 = 0; issue_use2 = 0;
    issue_wen = 0; issue_wreg = 0; rf_rd1 = 0; rf_rd2 = 0;
    wb_valid = 0; wb_skip = 0; wb_reg = 0; wb_data = 0; flush = 0; op_ready = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got %b exp 0", op_valid); end
    checks++; if (op_a !== 16'h0 || op_b !== 16'h0) begin failures++; $display("FAIL reset_ops got %h/%h exp 0/0", op_a, op_b); end
    checks++; if (op_wen !== 1'b0 || op_wreg !== 3'd0) begin failures++; $display("FAIL reset_wr got %b/%0d exp 0/0", op_wen, op_wreg); end
    checks++; if (dirty_vec !== 8'h00) begin failures++; $display("FAIL reset_dirty got %h exp 00", dirty_vec); end
`ifdef OPREAD_STALL_STATS_EN
    checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
`endif
    rst = 1;
    tick();
  endtask

  task automatic test_basic();
    // r1 <- r2 + r3
    issue_valid = 1; issue_rreg1 = 2; issue_rreg2 = 3; issue_use1 = 1; issue_use2 = 1;
    issue_wen = 1; issue_wreg = 1; rf_rd1 = 16'd5; rf_rd2 = 16'd7;
    #1;
    checks++; if (rf_rreg1 !== 3'd2 || rf_rreg2 !== 3'd3) begin failures++; $display("FAIL basic_rf_addr got %0d/%0d exp 2/3", rf_rreg1, rf_rreg2); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got %b exp 1", issue_ready); end
    tick();
    idle();
    checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL basic_op_valid got %b exp 1", op_valid); end
    checks++; if (op_a !== 16'd5 || op_b !== 16'd7) begin failures++; $display("FAIL basic_ops got %h/%h exp 0005/0007", op_a, op_b); end
    checks++; if (op_wen !== 1'b1 || op_wreg !== 3'd1) begin failures++; $display("FAIL basic_wr got %b/%0d exp 1/1", op_wen, op_wreg); end
    checks++; if (dirty_vec !== 8'h02) begin failures++; $display("FAIL basic_dirty got %h exp 02", dirty_vec); end
    wb_valid = 1; wb_reg = 1; wb_data = 16'hBEEF;
    tick();
    idle();
    checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got %b exp 0", op_valid); end
    checks++; if (dirty_vec !== 8'h00) begin failures++; $display("FAIL basic_clear got %h exp 00", dirty_vec); end
  endtask

  task automatic test_raw(input logic skip, input logic [15:0] exp_a);
    issue_valid = 1; issue_wen = 1; issue_wreg = 4;
    tick();
    idle();
    checks++; if (dirty_vec !== 8'h10) begin failures++; $display("FAIL raw_set skip=%b got %h exp 10", skip, dirty_vec); end
    issue_valid = 1; issue_rreg1 = 4; issue_use1 = 1; rf_rd1 = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_stall skip=%b cyc=%0d got %b exp 0", skip, i, issue_ready); end
      tick();
    end
    wb_valid = 1; wb_skip = skip; wb_reg = 4; wb_data = 16'h00AA;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_release skip=%b got %b exp 1", skip, issue_ready); end
    tick();
    idle();
    checks++; if (op_a !== exp_a) begin failures++; $display("FAIL raw_op_a skip=%b got %h exp %h", skip, op_a, exp_a); end
    checks++; if (dirty_vec !== 8'h00) begin failures++; $display("FAIL raw_clear skip=%b got %h exp 00", skip, dirty_vec); end
    tick();
  endtask

  task automatic test_waw();
    issue_valid = 1; issue_wen = 1; issue_wreg = 2;
    tick();
    checks++; if (dirty_vec !== 8'h04) begin failures++; $display("FAIL waw_set got %h exp 04", dirty_vec); end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_stall cyc=%0d got %b exp 0", i, issue_ready); end
      tick();
    end
    wb_valid = 1; wb_reg = 2; wb_data = 16'h5555;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL waw_release got %b exp 1", issue_ready); end
    tick();
    idle();
    checks++; if (dirty_vec !== 8'h04) begin failures++; $display("FAIL waw_set_wins got %h exp 04", dirty_vec); end
    checks++; if (op_valid !== 1'b1 || op_wreg !== 3'd2) begin failures++; $display("FAIL waw_op got %b/%0d exp 1/2", op_valid, op_wreg); end
    wb_valid = 1; wb_reg = 2;
    tick();
    idle();
    checks++; if (dirty_vec !== 8'h00) begin failures++; $display("FAIL waw_clear got %h exp 00", dirty_vec); end
  endtask

  task automatic test_hold();
    op_ready = 0;
    issue_valid = 1; issue_rreg1 = 5; issue_use1 = 1; rf_rd1 = 16'h1234;
    tick();
    issue_rreg1 = 6; rf_rd1 = 16'h5678;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL hold_ready cyc=%0d got %b exp 0", i, issue_ready); end
      checks++; if (op_valid !== 1'b1 || op_a !== 16'h1234) begin failures++; $display("FAIL hold_stable cyc=%0d got %b/%h exp 1/1234", i, op_valid, op_a); end
      tick();
    end
    op_ready = 1;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL hold_release got %b exp 1", issue_ready); end
    tick();
    idle();
    checks++; if (op_valid !== 1'b1 || op_a !== 16'h5678) begin failures++; $display("FAIL hold_next got %b/%h exp 1/5678", op_valid, op_a); end
    tick();
    checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL hold_drain got %b exp 0", op_valid); end
  endtask

  task automatic test_back_to_back_flush();
    for (int r = 4; r < 8; r++) begin
      issue_valid = 1; issue_wen = 1; issue_wreg = 3'(r);
      #1;
      checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready r=%0d got %b exp 1", r, issue_ready); end
      tick();
      checks++; if (op_valid !== 1'b1 || op_wreg !== 3'(r)) begin failures++; $display("FAIL b2b_op r=%0d got %b/%0d exp 1/%0d", r, op_valid, op_wreg, r); end
    end
    checks++; if (dirty_vec !== 8'hF0) begin failures++; $display("FAIL b2b_dirty got %h exp F0", dirty_vec); end
`ifdef OPREAD_STALL_STATS_EN
    checks++; if (stall_cnt !== 16'd12) begin failures++; $display("FAIL stall_cnt_total got %0d exp 12", stall_cnt); end
`endif
    flush = 1; op_ready = 0; issue_valid = 1; issue_wen = 1; issue_wreg = 0;
    wb_valid = 1; wb_reg = 4;
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got %b exp 0", issue_ready); end
    tick();
    idle();
    checks++; if (dirty_vec !== 8'h00 || op_valid !== 1'b0) begin failures++; $display("FAIL flush_state got %h/%b exp 00/0", dirty_vec, op_valid); end
`ifdef OPREAD_STALL_STATS_EN
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL flush_stall_cnt got %0d exp 0", stall_cnt); end
`endif
  endtask

  task automatic test_reset_mid_hold();
    op_ready = 0; issue_valid = 1; issue_wen = 1; issue_wreg = 3;
    tick();
    issue_valid = 0; issue_wen = 0;
    checks++; if (op_valid !== 1'b1 || dirty_vec !== 8'h08) begin failures++; $display("FAIL midrst_pre got %b/%h exp 1/08", op_valid, dirty_vec); end
    #2;
    rst = 0;
    #1;
    checks++; if (op_valid !== 1'b0 || dirty_vec !== 8'h00 || op_wen !== 1'b0) begin failures++; $display("FAIL midrst_async got %b/%h/%b exp 0/00/0", op_valid, dirty_vec, op_wen); end
    tick();
    rst = 1;
    idle();
    tick();
    tick();
    checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL midrst_after got %b exp 0", op_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw(1'b0, 16'h00AA);
    test_raw(1'b1, 16'h0011);
    test_waw();
    test_hold();
    test_back_to_back_flush();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
